// File: rtl/if_fetch.sv
// Y86 fetch stage: reads instruction bytes one at a time from a byte-wide memory, sizes each
// instruction from its icode and hands a packed 48-bit word to decode.
// Optional feature: define FETCH_HALT_EN to park fetching after a halt or illegal icode is accepted.
module if_fetch #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INST_W   = 48,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [7:0]        imem_data_i,
  input  logic              pc_load_i,
  input  logic [PC_W-1:0]   pc_new_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_err_o
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     drain_addr_q, drain_addr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          len_q, len_d;
  logic [INST_W-1:0]   buf_q, buf_d;
  logic [2:0]          cur_len;
  logic [2:0]          cnt_inc;
  logic [3:0]          icode;
  logic                halted_q;

  // Instruction length in bytes from icode; illegal codes are treated as 1 byte.
  function automatic logic [2:0] inst_len(input logic [3:0] code);
    logic [2:0] len;
    case (code)
      4'h0, 4'h1, 4'h9:       len = 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 3'd2;
      4'h7, 4'h8:             len = 3'd5;
      4'h3, 4'h4, 4'h5:       len = 3'd6;
      default:                len = 3'd1;
    endcase
    return len;
  endfunction

  assign icode = buf_q[INST_W-1 -: 4];

`ifdef FETCH_HALT_EN
  logic halted_d;

  // Park after accepting halt or an illegal icode; a redirect un-parks.
  always_comb begin
    halted_d = halted_q;
    if (pc_load_i) begin
      halted_d = 1'b0;
    end else if (state_q == StHold && inst_ready_i && (icode == 4'h0 || icode > 4'hB)) begin
      halted_d = 1'b1;
    end
  end

  // Halt-park flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) halted_q <= 1'b0;
    else         halted_q <= halted_d;
  end
`else
  assign halted_q = 1'b0;
`endif

  // Next-state, byte capture and memory request logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    buf_d        = buf_q;
    cur_len      = len_q;
    cnt_inc      = 3'(cnt_q + 3'd1);
    imem_req_o   = 1'b0;
    imem_addr_o  = pc_q + PC_W'(cnt_q);
    unique case (state_q)
      StFetch: begin
        // Gated by reset so an in-flight request drops the moment reset asserts.
        imem_req_o = rst_ni & ~halted_q;
        if (pc_load_i) begin
          pc_d  = pc_new_i;
          cnt_d = '0;
          buf_d = '0;
          // Without an ack this cycle the old request is still outstanding.
          if (!imem_ack_i && !halted_q) begin
            state_d      = StDrain;
            drain_addr_d = pc_q + PC_W'(cnt_q);
          end
        end else if (imem_ack_i && !halted_q) begin
          buf_d = buf_q | ({imem_data_i, {(INST_W-8){1'b0}}} >> (8 * cnt_q));
          if (cnt_q == 3'd0) begin
            cur_len = inst_len(imem_data_i[7:4]);
            len_d   = cur_len;
          end
          cnt_d = cnt_inc;
          if (cnt_inc == cur_len) state_d = StHold;
        end
      end
      StHold: begin
        if (pc_load_i) begin
          pc_d    = pc_new_i;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = StFetch;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + PC_W'(len_q);
          cnt_d   = '0;
          buf_d   = '0;
          state_d = StFetch;
        end
      end
      StDrain: begin
        imem_req_o  = rst_ni;
        imem_addr_o = drain_addr_q;
        if (pc_load_i) pc_d = pc_new_i;
        if (imem_ack_i) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      buf_q        <= buf_d;
    end
  end

  assign inst_valid_o = (state_q == StHold);
  assign pc_o         = inst_valid_o ? pc_q : '0;
  assign inst_o       = inst_valid_o ? buf_q : '0;
  assign inst_err_o   = inst_valid_o & (icode > 4'hB);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: table of single instructions plus hand sequences for
// throughput, stall, redirect/drain, wrap-around and reset corner cases.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_data;
  logic        pc_load;
  logic [15:0] pc_new;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] pc_out;
  logic [47:0] inst_out;
  logic        inst_err;

  int errors = 0;
  int checks = 0;

  // Memory model state.
  logic [7:0] mem [0:65535];
  int         mem_delay = 0;
  int         wcnt = 0;
  logic       mdl_ack = 1'b0;
  logic [7:0] mdl_data = 8'h00;
  logic       manual = 1'b0;
  logic       man_ack = 1'b0;
  logic [7:0] man_data = 8'h00;

  assign imem_ack  = manual ? man_ack : mdl_ack;
  assign imem_data = manual ? man_data : mdl_data;

  always #5 clk = ~clk;

  if_fetch #(.PC_W(16), .INST_W(48), .RESET_PC(16'h0000)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ack_i  (imem_ack),
    .imem_data_i (imem_data),
    .pc_load_i   (pc_load),
    .pc_new_i    (pc_new),
    .inst_valid_o(inst_valid),
    .inst_ready_i(inst_ready),
    .pc_o        (pc_out),
    .inst_o      (inst_out),
    .inst_err_o  (inst_err)
  );

  // Byte memory with a configurable number of wait cycles before each ack.
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      mdl_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= mem_delay) begin
      mdl_ack  = 1'b1;
      mdl_data = mem[imem_addr];
      wcnt     = 0;
    end else begin
      mdl_ack = 1'b0;
      wcnt++;
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [47:0] bytes_in;
    logic [47:0] exp_inst;
    logic        exp_err;
    logic [2:0]  len;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic redirect(input logic [15:0] a);
    @(negedge clk);
    pc_load = 1'b1;
    pc_new  = a;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(inst_valid), 64'd1);
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [47:0] b;
    b = v.bytes_in;
    for (int k = 0; k < 6; k++) mem[16'(v.addr + 16'(k))] = b[47-8*k -: 8];
    redirect(v.addr);
    wait_valid($sformatf("v%0d_valid", idx));
    chk($sformatf("v%0d_pc", idx), 64'(pc_out), 64'(v.addr));
    chk($sformatf("v%0d_inst", idx), 64'(inst_out), 64'(v.exp_inst));
    chk($sformatf("v%0d_err", idx), 64'(inst_err), 64'(v.exp_err));
    accept();
    chk($sformatf("v%0d_dropvalid", idx), 64'(inst_valid), 64'd0);
`ifdef FETCH_HALT_EN
    if (v.exp_err) chk($sformatf("v%0d_parked", idx), 64'(imem_req), 64'd0);
    else chk($sformatf("v%0d_nextaddr", idx), 64'(imem_addr), 64'(16'(v.addr + 16'(v.len))));
`else
    chk($sformatf("v%0d_nextaddr", idx), 64'(imem_addr), 64'(16'(v.addr + 16'(v.len))));
`endif
  endtask

  initial begin
    int n;
    logic [47:0] held;
    rst_n      = 1'b0;
    pc_load    = 1'b0;
    pc_new     = 16'h0000;
    inst_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;

    vecs[0]  = '{16'h0040, 48'h30F378563412, 48'h30F378563412, 1'b0, 3'd6};
    vecs[1]  = '{16'h0100, 48'h10AABBCCDDEE, 48'h100000000000, 1'b0, 3'd1};
    vecs[2]  = '{16'h0200, 48'h2012AABBCCDD, 48'h201200000000, 1'b0, 3'd2};
    vecs[3]  = '{16'h0300, 48'h7000040000AA, 48'h700004000000, 1'b0, 3'd5};
    vecs[4]  = '{16'h0400, 48'h6123FFFFFFFF, 48'h612300000000, 1'b0, 3'd2};
    vecs[5]  = '{16'h0500, 48'hD5AABBCCDDEE, 48'hD50000000000, 1'b1, 3'd1};
    vecs[6]  = '{16'h0600, 48'h8000010000EE, 48'h800001000000, 1'b0, 3'd5};
    vecs[7]  = '{16'h0700, 48'hB0F8AABBCCDD, 48'hB0F800000000, 1'b0, 3'd2};
    vecs[8]  = '{16'h0800, 48'h90AABBCCDDEE, 48'h900000000000, 1'b0, 3'd1};
    vecs[9]  = '{16'h0900, 48'h40123456789A, 48'h40123456789A, 1'b0, 3'd6};
    vecs[10] = '{16'h0A80, 48'h50123456789A, 48'h50123456789A, 1'b0, 3'd6};
    vecs[11] = '{16'h0B80, 48'hA0F8AABBCCDD, 48'hA0F800000000, 1'b0, 3'd2};

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst_out), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'd0);
    chk("rst_err", 64'(inst_err), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait stream with inst_ready tied high: 10 / 20 30 / 00.
    @(negedge clk);
    chk("t1_req", 64'(imem_req), 64'd1);
    chk("t1_addr", 64'(imem_addr), 64'h0000);
    wait_valid("t1_nop_valid");
    chk("t1_nop_pc", 64'(pc_out), 64'h0000);
    chk("t1_nop_inst", 64'(inst_out), 64'h100000000000);
    n = 0;
    do begin @(negedge clk); n++; end while (!inst_valid && n < 10);
    chk("t1_rr_gap", 64'(n), 64'd3);
    chk("t1_rr_pc", 64'(pc_out), 64'h0001);
    chk("t1_rr_inst", 64'(inst_out), 64'h203000000000);
    n = 0;
    do begin @(negedge clk); n++; end while (!inst_valid && n < 10);
    chk("t1_halt_gap", 64'(n), 64'd2);
    chk("t1_halt_pc", 64'(pc_out), 64'h0003);
    inst_ready = 1'b0;
    @(negedge clk);
`ifdef FETCH_HALT_EN
    chk("t1_parked", 64'(imem_req), 64'd0);
`else
    chk("t1_cont_addr", 64'(imem_addr), 64'h0004);
`endif

    // Table, with zero-wait and with one-wait memory.
    for (int d = 0; d < 2; d++) begin
      mem_delay = d;
      for (int i = 0; i < 12; i++) run_vec(vecs[i], i + 12 * d);
    end

    // Stall in HOLD with one-wait memory.
    mem_delay = 1;
    mem[16'h0A00] = 8'h20; mem[16'h0A01] = 8'h45;
    redirect(16'h0A00);
    wait_valid("t3_valid");
    held = inst_out;
    chk("t3_inst", 64'(held), 64'h204500000000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t3_stable%0d", c), 64'(inst_out), 64'(held));
      chk($sformatf("t3_noreq%0d", c), 64'(imem_req), 64'd0);
    end
    accept();
    chk("t3_resume_req", 64'(imem_req), 64'd1);
    chk("t3_resume_addr", 64'(imem_addr), 64'h0A02);

    // Redirect with a request outstanding, then redirect mid-jxx; last pending target wins.
    manual  = 1'b1;
    man_ack = 1'b0;
    pc_load = 1'b1;
    pc_new  = 16'h0B00;
    @(negedge clk);
    pc_load = 1'b0;
    chk("t4_drain0_addr", 64'(imem_addr), 64'h0A02);
    man_ack = 1'b1; man_data = 8'h55;
    @(negedge clk);
    chk("t4_b0_addr", 64'(imem_addr), 64'h0B00);
    man_ack = 1'b1; man_data = 8'h70;
    @(negedge clk);
    chk("t4_b1_addr", 64'(imem_addr), 64'h0B01);
    man_data = 8'h00;
    @(negedge clk);
    chk("t4_b2_addr", 64'(imem_addr), 64'h0B02);
    man_ack = 1'b0;
    pc_load = 1'b1;
    pc_new  = 16'h0100;
    @(negedge clk);
    chk("t4_drain_req", 64'(imem_req), 64'd1);
    chk("t4_drain_addr", 64'(imem_addr), 64'h0B02);
    chk("t4_drain_valid", 64'(inst_valid), 64'd0);
    pc_new = 16'h0120;
    @(negedge clk);
    pc_load = 1'b0;
    chk("t4_drain_addr2", 64'(imem_addr), 64'h0B02);
    man_ack = 1'b1; man_data = 8'hAA;
    @(negedge clk);
    man_ack = 1'b0;
    chk("t4_new_req", 64'(imem_req), 64'd1);
    chk("t4_new_addr", 64'(imem_addr), 64'h0120);
    chk("t4_no_stale", 64'(inst_valid), 64'd0);
    @(negedge clk);
    chk("t4_wait_addr", 64'(imem_addr), 64'h0120);
    chk("t4_wait_valid", 64'(inst_valid), 64'd0);
    manual    = 1'b0;
    mem_delay = 0;

    // Illegal icode at FFFF, wrap to 0000 and a 2-byte opcode there.
    mem[16'hFFFF] = 8'hF0; mem[16'h0000] = 8'h60; mem[16'h0001] = 8'h12;
    redirect(16'hFFFF);
    wait_valid("t5_err_valid");
    chk("t5_err_pc", 64'(pc_out), 64'hFFFF);
    chk("t5_err_flag", 64'(inst_err), 64'd1);
    chk("t5_err_inst", 64'(inst_out), 64'hF00000000000);
    accept();
`ifdef FETCH_HALT_EN
    chk("t5_parked", 64'(imem_req), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_still_parked", 64'(imem_req), 64'd0);
    redirect(16'h0000);
`else
    chk("t5_wrap_addr", 64'(imem_addr), 64'h0000);
`endif
    wait_valid("t5_op_valid");
    chk("t5_op_pc", 64'(pc_out), 64'h0000);
    chk("t5_op_inst", 64'(inst_out), 64'h601200000000);
    chk("t5_op_err", 64'(inst_err), 64'd0);
    accept();

    // Reset in the middle of a 5-byte call.
    mem[16'h0C00] = 8'h80; mem[16'h0C01] = 8'h11; mem[16'h0C02] = 8'h22;
    mem[16'h0C03] = 8'h33; mem[16'h0C04] = 8'h44;
    redirect(16'h0C00);
    n = 0;
    while (!(imem_req && imem_addr == 16'h0C02) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_b2", 64'(imem_addr), 64'h0C02);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 64'(imem_req), 64'd0);
    chk("t6_rst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart_req", 64'(imem_req), 64'd1);
    chk("t6_restart_addr", 64'(imem_addr), 64'h0000);
    chk("t6_restart_valid", 64'(inst_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
